// File: rtl/veggie_pkg.sv
// Shared constants and types for the frame-buffer write engine.
package veggie_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 8;

  typedef enum logic {OP_FILL, OP_CLEAR} fw_op_t;

  typedef enum logic [1:0] {FW_IDLE, FW_SETUP, FW_FILL, FW_DONE} fw_state_t;

  // Exclusive end coordinate clipped to the screen; 11 bits so start+len never wraps.
  function automatic logic [10:0] clip_end(input logic [9:0] start, input logic [9:0] len,
                                           input logic [10:0] limit);
    logic [10:0] sum;
    sum = {1'b0, start} + {1'b0, len};
    return (sum > limit) ? limit : sum;
  endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Rectangle scan address generator: column/row counters, row base accumulator,
// last-pixel flag and the registered frame-buffer write address.
module frame_addr_gen
  import veggie_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [9:0]        x_start,
  input  logic [9:0]        y_start,
  input  logic [10:0]       x_end,
  input  logic [10:0]       y_end,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last
);

  logic [9:0]        cx;
  logic [9:0]        cy;
  logic [9:0]        x0;
  logic [10:0]       xe;
  logic [10:0]       ye;
  logic [ADDR_W-1:0] row_base;
  logic              row_end;

  assign row_end = ({1'b0, cx} == xe - 11'd1);
  assign last    = row_end && ({1'b0, cy} == ye - 11'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx       <= '0;
      cy       <= '0;
      x0       <= '0;
      xe       <= '0;
      ye       <= '0;
      row_base <= '0;
      wr_addr  <= '0;
    end else if (load) begin
      cx       <= x_start;
      cy       <= y_start;
      x0       <= x_start;
      xe       <= x_end;
      ye       <= y_end;
      // y*640 as y*512 + y*128
      row_base <= ({9'b0, y_start} << 9) + ({9'b0, y_start} << 7);
    end else if (step) begin
      wr_addr <= row_base + {9'b0, cx};
      if (row_end) begin
        cx       <= x0;
        cy       <= cy + 10'd1;
        row_base <= row_base + ADDR_W'(H_RES);
      end else begin
        cx <= cx + 10'd1;
      end
    end
  end

endmodule

// File: rtl/frame_writer.sv
// Frame-buffer write engine: rectangle fill / screen clear, one pixel per clock.
// Optional FRAME_WRITER_VBLANK_SYNC_EN: accept commands only while vs is low.
module frame_writer
  import veggie_pkg::*;
(
  input  logic               Clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [9:0]         cmd_x,
  input  logic [9:0]         cmd_y,
  input  logic [9:0]         cmd_w,
  input  logic [9:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               vs,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output fw_state_t          dbg_state
);

  fw_state_t          state_q, state_d;
  logic [9:0]         x_q, y_q, w_q, h_q;
  logic [COLOR_W-1:0] color_q;
  logic               accept, degenerate, load, step, last;
  logic [10:0]        x_end, y_end;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_* are sampled only on that edge.
`ifdef FRAME_WRITER_VBLANK_SYNC_EN
  logic vs_s1, vs_q;
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_s1 <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      vs_s1 <= vs;
      vs_q  <= vs_s1;
    end
  end
  assign cmd_ready = reset_n && (state_q == FW_IDLE) && !vs_q;
`else
  logic unused_vs;
  assign unused_vs = vs;
  assign cmd_ready = reset_n && (state_q == FW_IDLE);
`endif

  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != FW_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
    end else if (accept) begin
      color_q <= cmd_color;
      if (fw_op_t'(cmd_op) == OP_CLEAR) begin
        x_q <= '0;
        y_q <= '0;
        w_q <= 10'(H_RES);
        h_q <= 10'(V_RES);
      end else begin
        x_q <= cmd_x;
        y_q <= cmd_y;
        w_q <= cmd_w;
        h_q <= cmd_h;
      end
    end
  end

  assign x_end      = clip_end(x_q, w_q, 11'(H_RES));
  assign y_end      = clip_end(y_q, h_q, 11'(V_RES));
  assign degenerate = (w_q == '0) || (h_q == '0) ||
                      (x_q >= 10'(H_RES)) || (y_q >= 10'(V_RES));

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state_q <= FW_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      FW_IDLE:  if (accept) state_d = FW_SETUP;
      FW_SETUP: begin
        if (degenerate) begin
          state_d = FW_DONE;
        end else begin
          load    = 1'b1;
          state_d = FW_FILL;
        end
      end
      FW_FILL: begin
        step = 1'b1;
        if (last) state_d = FW_DONE;
      end
      FW_DONE:  state_d = FW_IDLE;
      default:  state_d = FW_IDLE;
    endcase
  end

  // Write strobe, data and done are registered alongside wr_addr.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      wr_en <= step;
      done  <= (state_q == FW_DONE);
      if (step) wr_data <= color_q;
    end
  end

  frame_addr_gen u_addr_gen (
    .clk     (Clk),
    .rst_n   (reset_n),
    .load    (load),
    .step    (step),
    .x_start (x_q),
    .y_start (y_q),
    .x_end   (x_end),
    .y_end   (y_end),
    .wr_addr (wr_addr),
    .last    (last)
  );

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
Frame-buffer write engine that sits directly upstream of the dual-port frame buffer. It drives the buffer's data, write-address and write-enable inputs, replacing the constant-high write enable. It accepts rectangle-fill and full-screen-clear commands, which NIOS software builds from the to_hw ports. Each command is clipped to the 640x480 screen and written as 8-bit colour, one pixel per clock.

Parameters:
H_RES, 640, visible pixels per line
V_RES, 480, visible lines
ADDR_W, 19, frame-buffer address width
COLOR_W, 8, pixel colour width

Ports:
Clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  1  0 = FILL rectangle, 1 = CLEAR screen
cmd_x  in  10  left column
cmd_y  in  10  top row
cmd_w  in  10  width in pixels
cmd_h  in  10  height in lines
cmd_color  in  COLOR_W  fill colour
vs  in  1  VGA vertical sync (active-low); used only with the optional feature
wr_en  out  1  frame-buffer write enable
wr_addr  out  ADDR_W  frame-buffer write address
wr_data  out  COLOR_W  frame-buffer write data
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async, reset_n=0): state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0. cmd_ready=1 once reset_n deasserts.
- States: IDLE -> SETUP -> FILL -> DONE -> IDLE. SETUP goes straight to DONE when the command is degenerate.
- IDLE:
  - cmd_ready=1, busy=0.
  - A handshake is cmd_valid & cmd_ready at a rising edge. On a handshake, all cmd_* fields are latched and the state moves to SETUP.
  - cmd_* fields are ignored when there is no handshake.
- CLEAR: treated as x=0, y=0, w=H_RES, h=V_RES with cmd_color. The cmd_x/y/w/h inputs are ignored.
- SETUP (1 cycle):
  - x_end = min(x+w, H_RES) and y_end = min(y+h, V_RES), computed at 11 bits so there is no overflow (x=1023, w=1023 is legal).
  - Degenerate when w==0, h==0, x>=H_RES or y>=V_RES. Degenerate -> DONE with no writes.
  - Otherwise compute row_base = y*H_RES by shift-add (y<<9 + y<<7 for 640), set cx=x, cy=y, and go to FILL.
- FILL:
  - One write per cycle: wr_en=1, wr_addr=row_base+cx, wr_data=colour. Outputs are registered.
  - cx increments each cycle. When cx==x_end-1: cx<=x, cy<=cy+1, row_base<=row_base+H_RES.
  - The write with cx==x_end-1 and cy==y_end-1 is the last; the state then goes to DONE.
- DONE: wr_en=0, done=1 for exactly one cycle, then IDLE.
- busy=1 in SETUP, FILL and DONE.
- Latency:
  - First write is visible 2 cycles after the handshake edge.
  - Total cycles from handshake to done pulse = clipped_pixels + 2.
  - Degenerate command: done pulse 2 cycles after the handshake.
- Back-to-back: cmd_ready returns the cycle after done. The minimum command spacing is N+3 cycles.
- Ordering: wr_addr is strictly increasing within a command. The maximum address is H_RES*V_RES-1 = 307199 and is never exceeded.
- Reset mid-FILL: all writes stop immediately. Pixels already written are not rolled back, no done pulse is issued, and the latched command is discarded.
- Inputs changing while busy: no effect.

Optional Feature:
- Macro: FRAME_WRITER_VBLANK_SYNC_EN.
- Defined:
  - cmd_ready = IDLE & ~vs_q, where vs_q is vs passed through a 2-flop synchronizer.
  - A command is accepted only during vertical sync, to avoid tearing.
  - A command already in progress runs to completion regardless of vs.
- Undefined: vs is ignored, cmd_ready = IDLE.

Decomposition:
- Package veggie_pkg holds:
  - constants H_RES, V_RES, ADDR_W, COLOR_W;
  - typedef enum fw_op_t {OP_FILL, OP_CLEAR};
  - typedef enum fw_state_t {FW_IDLE, FW_SETUP, FW_FILL, FW_DONE}.
- One natural sub-module: frame_addr_gen. It holds the cx/cy counters, row_base accumulator, last-pixel flag and wr_addr register. The top holds the FSM and handshake.

Test Plan:
- FILL x=10 y=5 w=2 h=2 color=0x3C -> writes exactly 3210, 3211, 3850, 3851 with data 0x3C on consecutive cycles; first write 2 cycles after accept; done 4+2 cycles after accept.
- FILL x=638 y=479 w=5 h=5 color=0xFF -> clipped to exactly two writes, 307198 and 307199; nothing larger.
- FILL w=0 (and separately x=700) -> zero writes; done 2 cycles after accept; cmd_ready high the next cycle.
- CLEAR color=0x00 -> 307200 consecutive writes with addresses 0..307199; done at cycle 307202; cmd_ready held low throughout.
- Assert reset_n low mid-FILL at pixel 100 -> wr_en=0 and busy=0 immediately (asynchronous); no done pulse; a new command after release executes normally.
- With FRAME_WRITER_VBLANK_SYNC_EN: cmd_valid held while vs=1 -> no accept; accept 3 cycles after vs falls. Without the macro -> accept in the first IDLE cycle.
